// File: rtl/std_mem_d1_loader_pkg.sv
// Shared types and helpers for the std_mem_d1 stream loader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package std_mem_d1_loader_pkg;

  // Loader FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Saturating minimum, used to clamp the requested length to the memory size
  function automatic int unsigned sat_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/std_mem_d1_loader.sv
// Streams valid/ready words into a std_mem_d1 memory at addresses 0..len-1.
// Latency: go->in_ready 1 cycle; 3 cycles/word best case; go->done 3N+2 cycles.
// Backpressure: in_ready only in ACCEPT; each write waits for mem_done before the next word.
module std_mem_d1_loader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   len,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IDX_SIZE-1:0] addr0,
  output logic [WIDTH-1:0]    write_data,
  output logic                write_en,
  input  logic                mem_done,
  output logic                done,
  output logic [IDX_SIZE:0]   count
);
  import std_mem_d1_loader_pkg::*;

  localparam int CW = IDX_SIZE + 1;

  state_t        state;
  logic [CW-1:0] idx;
  logic [CW-1:0] len_q;
  logic [CW-1:0] len_sat;
  logic [CW-1:0] idx_next;

  // Requested length clamped to the memory depth so addr0 can never pass SIZE-1
  assign len_sat  = CW'(sat_min(32'(len), 32'(SIZE)));
  assign idx_next = idx + CW'(1);

  // Single FSM with registered outputs; in_ready/write_en are set on entry to
  // ACCEPT/WRITE, and done is raised from FINISH so it lands one cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      count      <= '0;
      len_q      <= '0;
      addr0      <= '0;
      write_data <= '0;
      in_ready   <= 1'b0;
      write_en   <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_ready <= 1'b0;
      write_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            len_q <= len_sat;
            idx   <= '0;
            count <= '0;
            if (len_sat == '0) begin
              state <= ST_FINISH;
            end else begin
              state    <= ST_ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            write_data <= in_data;
            addr0      <= idx[IDX_SIZE-1:0];
            write_en   <= 1'b1;
            state      <= ST_WRITE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // No timeout: a memory that never answers parks the loader here
          if (mem_done) begin
            idx   <= idx_next;
            count <= count + CW'(1);
            if (idx_next == len_q) begin
              state <= ST_FINISH;
            end else begin
              state    <= ST_ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_mem_d1_loader.sv
// Directed table-driven bench for std_mem_d1_loader with a small memory/producer model.
// Latency: expected go->done cycle counts are hand-computed per vector.
// Backpressure: producer inserts in_valid gaps; memory answers mem_done after a per-vector delay.
module tb_std_mem_d1_loader;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                go;
  logic [IDX_SIZE:0]   len;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [IDX_SIZE-1:0] addr0;
  logic [WIDTH-1:0]    write_data;
  logic                write_en;
  logic                mem_done;
  logic                done;
  logic [IDX_SIZE:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  std_mem_d1_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
    .clk(clk), .reset(reset), .go(go), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .addr0(addr0), .write_data(write_data), .write_en(write_en),
    .mem_done(mem_done), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          gap;        // ACCEPT cycles with in_valid low before data is offered
    int          mdly;       // cycles from write_en to mem_done
    logic [31:0] base;       // data for word i is base+i
    int          exp_words;
    int          exp_done;   // cycle of done, counting the go cycle as 0
    int          busy_go_at; // cycle at which a stray go is pulsed, -1 for none
    int          abort_after;// reset after this many mem_done, 0 for none
    int          exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".in_ready"},   longint'(in_ready), 0);
    chk({tag, ".write_en"},   longint'(write_en), 0);
    chk({tag, ".done"},       longint'(done), 0);
    chk({tag, ".addr0"},      longint'(addr0), 0);
    chk({tag, ".write_data"}, longint'(write_data), 0);
    chk({tag, ".count"},      longint'(count), 0);
  endtask

  task automatic run_transfer(input int vi, input vec_t v);
    int   cyc;
    int   nw;
    int   nacc;
    int   wait_acc;
    int   timer;
    int   ndone;
    int   done_cyc;
    int   nmd;
    int   nrdy;
    bit   finished;
    logic prev_we;
    string tag;
    tag      = $sformatf("v%0d", vi);
    cyc      = 0;
    nw       = 0;
    nacc     = 0;
    wait_acc = 0;
    timer    = 0;
    ndone    = 0;
    done_cyc = -1;
    nmd      = 0;
    nrdy     = 0;
    finished = 1'b0;
    prev_we  = 1'b0;

    @(negedge clk);
    go  = 1'b1;
    len = v.len[IDX_SIZE:0];

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      go = 1'b0;
      if (cyc == v.busy_go_at) begin
        go  = 1'b1;
        len = 5'd5;
      end

      if (in_ready) nrdy++;
      if (write_en) begin
        chk($sformatf("%s.we_single_cycle", tag), longint'(prev_we), 0);
        chk($sformatf("%s.ready_excl_we", tag), longint'(in_ready), 0);
        chk($sformatf("%s.addr%0d", tag, nw), longint'(addr0), nw);
        chk($sformatf("%s.data%0d", tag, nw), longint'(write_data), longint'(v.base + 32'(nw)));
        nw++;
      end
      prev_we = write_en;

      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk($sformatf("%s.count_at_done", tag), longint'(count), v.exp_count);
      end

      mem_done = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          mem_done = 1'b1;
          nmd++;
        end
      end
      if (write_en) begin
        timer    = v.mdly;
        wait_acc = 0;
      end

      if (in_ready) begin
        if (wait_acc < v.gap) begin
          in_valid = 1'b0;
          // spurious mem_done while the loader is accepting must be ignored
          if (wait_acc == 0) mem_done = 1'b1;
          wait_acc++;
        end else begin
          in_valid = 1'b1;
          in_data  = v.base + 32'(nacc);
          nacc++;
        end
      end else begin
        in_valid = 1'b0;
      end

      if (v.abort_after > 0 && nmd == v.abort_after) begin
        finished = 1'b1;
        break;
      end
      if (ndone > 0 && cyc >= done_cyc + 2) begin
        finished = 1'b1;
        break;
      end
    end

    chk($sformatf("%s.no_timeout", tag), longint'(finished), 1);
    chk($sformatf("%s.words", tag), nw, v.exp_words);

    if (v.abort_after > 0) begin
      @(negedge clk);
      reset    = 1'b1;
      mem_done = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_idle_outputs($sformatf("%s.after_reset", tag));
      chk($sformatf("%s.done_pulses", tag), ndone, 0);
      reset = 1'b0;
    end else begin
      chk($sformatf("%s.done_cycle", tag), done_cyc, v.exp_done);
      chk($sformatf("%s.done_pulses", tag), ndone, 1);
      chk($sformatf("%s.count_hold", tag), longint'(count), v.exp_count);
      chk($sformatf("%s.ready_cycles", tag), nrdy, v.exp_words * (v.gap + 1));
    end
    mem_done = 1'b0;
    in_valid = 1'b0;
    go       = 1'b0;
  endtask

  initial begin
    //            len gap mdly base   words done busy abort count
    vecs[0] = '{len:4,  gap:0, mdly:1, base:32'hA0,  exp_words:4,  exp_done:14, busy_go_at:-1, abort_after:0, exp_count:4};
    vecs[1] = '{len:0,  gap:0, mdly:1, base:32'hB0,  exp_words:0,  exp_done:2,  busy_go_at:-1, abort_after:0, exp_count:0};
    vecs[2] = '{len:20, gap:0, mdly:1, base:32'h100, exp_words:16, exp_done:50, busy_go_at:-1, abort_after:0, exp_count:16};
    vecs[3] = '{len:3,  gap:2, mdly:3, base:32'hC0,  exp_words:3,  exp_done:23, busy_go_at:-1, abort_after:0, exp_count:3};
    vecs[4] = '{len:3,  gap:0, mdly:1, base:32'hD0,  exp_words:3,  exp_done:11, busy_go_at:5,  abort_after:0, exp_count:3};
    vecs[5] = '{len:8,  gap:0, mdly:1, base:32'hE0,  exp_words:3,  exp_done:-1, busy_go_at:-1, abort_after:3, exp_count:0};
    vecs[6] = '{len:2,  gap:0, mdly:1, base:32'hF0,  exp_words:2,  exp_done:8,  busy_go_at:-1, abort_after:0, exp_count:2};
    vecs[7] = '{len:1,  gap:1, mdly:2, base:32'h55,  exp_words:1,  exp_done:7,  busy_go_at:-1, abort_after:0, exp_count:1};

    reset    = 1'b1;
    go       = 1'b0;
    len      = '0;
    in_data  = '0;
    in_valid = 1'b0;
    mem_done = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_transfer(i, vecs[i]);
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
